// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered multi-cycle ALU with persistent carry and iterative shifter
//
// Accepts one operation per in_valid/in_ready handshake and presents a
// registered result plus C/Z/N/V flags on an out_valid/out_ready handshake.
// Arithmetic and logic ops, illegal opcodes and zero-amount shifts complete
// on the accept edge. Shifts by N>0 run one bit per cycle in the SHIFT state.
//
// Optional build macro: ALU_SEQ_BARREL_EN
//   defined   - shifts/rotate use a single-cycle barrel shifter; SHIFT is
//               never entered and busy is tied low.
//   undefined - iterative shifter, result appears N+1 edges after accept.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid, in_ready    operation request handshake
//   op, a, b              opcode, operands (b[SHW-1:0] is the shift amount)
//   out_valid, out_ready  result handshake
//   result                registered result
//   flag_c/z/n/v          carry-borrow (persistent), zero, negative, overflow
//   op_err                current result came from an illegal opcode
//   busy                  iterative shift in progress

module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic             op_err,
    output logic             busy
);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_ADC = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_SBB = 4'h3;
    localparam logic [3:0] OP_ASR = 4'h4;
    localparam logic [3:0] OP_LSR = 4'h5;
    localparam logic [3:0] OP_ROR = 4'h6;
    localparam logic [3:0] OP_CLR = 4'h7;
    localparam logic [3:0] OP_OR  = 4'h8;
    localparam logic [3:0] OP_AND = 4'h9;
    localparam logic [3:0] OP_XOR = 4'hA;
    localparam logic [3:0] OP_NOT = 4'hB;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [3:0]       sh_op_q, sh_op_d;
    logic             c_q, c_d;
    logic             z_q, z_d;
    logic             n_q, n_d;
    logic             v_q, v_d;
    logic             err_q, err_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic             pop;
    logic [SHW-1:0]   sh_amt;
    logic             is_shift;
    logic             defer_shift;

    // Single-cycle result path, used for everything except deferred shifts
    logic             cin;
    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic [WIDTH-1:0] sh_val;
    logic [WIDTH-1:0] imm_res;
    logic             imm_c;
    logic             imm_v;
    logic             imm_legal;

    // One-bit step of ASR / LSR / ROR; any other code is treated as ROR
    function automatic logic [WIDTH-1:0] shift_one(input logic [3:0] sop,
                                                   input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        case (sop)
            OP_ASR:  r = {v[WIDTH-1], v[WIDTH-1:1]};
            OP_LSR:  r = {1'b0, v[WIDTH-1:1]};
            default: r = {v[0], v[WIDTH-1:1]};
        endcase
        return r;
    endfunction

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid_q && out_ready;
    assign sh_amt   = b[SHW-1:0];
    assign is_shift = (op == OP_ASR) || (op == OP_LSR) || (op == OP_ROR);

`ifdef ALU_SEQ_BARREL_EN
    assign defer_shift = 1'b0;
    assign busy        = 1'b0;
`else
    // Amount 0 shifts bypass SHIFT and complete like any other op
    assign defer_shift = is_shift && (sh_amt != '0);
    assign busy        = (state_q == SHIFT);
`endif

    always_comb begin
        // ADC/SBB consume the carry as registered at the accept edge
        cin     = ((op == OP_ADC) || (op == OP_SBB)) ? c_q : 1'b0;
        add_ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        sub_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};

        sh_val = a;
`ifdef ALU_SEQ_BARREL_EN
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (i < int'(sh_amt)) begin
                sh_val = shift_one(op, sh_val);
            end
        end
`endif

        imm_res   = '0;
        imm_c     = c_q;
        imm_v     = 1'b0;
        imm_legal = 1'b1;
        case (op)
            OP_ADD, OP_ADC: begin
                imm_res = add_ext[WIDTH-1:0];
                imm_c   = add_ext[WIDTH];
                imm_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_SBB: begin
                // Bit WIDTH of the extended difference is the borrow out
                imm_res = sub_ext[WIDTH-1:0];
                imm_c   = sub_ext[WIDTH];
                imm_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ASR, OP_LSR, OP_ROR: imm_res = sh_val;
            OP_CLR:                 imm_res = '0;
            OP_OR:                  imm_res = a | b;
            OP_AND:                 imm_res = a & b;
            OP_XOR:                 imm_res = a ^ b;
            OP_NOT:                 imm_res = ~a;
            default:                imm_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        sh_op_d     = sh_op_q;
        c_d         = c_q;
        z_d         = z_q;
        n_d         = n_q;
        v_d         = v_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;

        if (pop) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (defer_shift) begin
                        work_d  = a;
                        cnt_d   = sh_amt;
                        sh_op_d = op;
                        state_d = SHIFT;
                    end else begin
                        out_valid_d = 1'b1;
                        if (imm_legal) begin
                            result_d = imm_res;
                            c_d      = imm_c;
                            z_d      = (imm_res == '0);
                            n_d      = imm_res[WIDTH-1];
                            v_d      = imm_v;
                            err_d    = 1'b0;
                        end else begin
                            // Illegal opcode leaves every flag untouched
                            result_d = '0;
                            err_d    = 1'b1;
                        end
                    end
                end
            end
            SHIFT: begin
                work_d = shift_one(sh_op_q, work_q);
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) begin
                    result_d    = work_d;
                    z_d         = (work_d == '0);
                    n_d         = work_d[WIDTH-1];
                    v_d         = 1'b0;
                    err_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            result_q    <= '0;
            work_q      <= '0;
            cnt_q       <= '0;
            sh_op_q     <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            v_q         <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            sh_op_q     <= sh_op_d;
            c_q         <= c_d;
            z_q         <= z_d;
            n_q         <= n_d;
            v_q         <= v_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag_c    = c_q;
    assign flag_z    = z_q;
    assign flag_n    = n_q;
    assign flag_v    = v_q;
    assign op_err    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq against an arithmetic model

module tb_alu_seq;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;
    localparam int MAXS = (1 << (W - 1)) - 1;
    localparam int MINS = -(1 << (W - 1));

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op_i = 4'h0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         flag_c, flag_z, flag_n, flag_v, op_err, busy;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op_i), .a(a_i), .b(b_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result),
        .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
        .op_err(op_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic c, z, n, v, err;
        int   lat;
        int   acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic pop_seen = 1'b0;
    logic was_valid = 1'b0;
    logic m_c = 1'b0, m_z = 1'b0, m_n = 1'b0, m_v = 1'b0;
    int   sh_acc = 0;
    int   sh_n = 0;
    logic [W-1:0] h_res = '0;
    logic h_c = 1'b0, h_z = 1'b0, h_n = 1'b0, h_v = 1'b0, h_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    // Reference: results from plain integer arithmetic on the opcode table
    function automatic exp_t model_step(input logic [3:0] o, input logic [W-1:0] av,
                                        input logic [W-1:0] bv);
        exp_t e;
        int ua, ub, sa, sb, r, sr, n, cin;
        e = '{default: 0};
        ua = int'(av);
        ub = int'(bv);
        sa = av[W-1] ? ua - (1 << W) : ua;
        sb = bv[W-1] ? ub - (1 << W) : ub;
        n  = ub % W;
        cin = 0;
        r  = 0;
        e.lat = 1;
        case (o)
            4'h0, 4'h1: begin
                if (o == 4'h1) cin = int'(m_c);
                r  = ua + ub + cin;
                sr = sa + sb + cin;
                m_c = (r > MASK);
                m_v = (sr > MAXS) || (sr < MINS);
            end
            4'h2, 4'h3: begin
                if (o == 4'h3) cin = int'(m_c);
                r  = ua - ub - cin;
                sr = sa - sb - cin;
                m_c = (r < 0);
                m_v = (sr > MAXS) || (sr < MINS);
            end
            4'h4, 4'h5, 4'h6: begin
                if (o == 4'h4)      r = sa >>> n;
                else if (o == 4'h5) r = ua >> n;
                else if (n == 0)    r = ua;
                else                r = (ua >> n) | (ua << (W - n));
                m_v = 1'b0;
`ifndef ALU_SEQ_BARREL_EN
                e.lat = n + 1;
`endif
            end
            4'h7: begin r = 0;        m_v = 1'b0; end
            4'h8: begin r = ua | ub;  m_v = 1'b0; end
            4'h9: begin r = ua & ub;  m_v = 1'b0; end
            4'hA: begin r = ua ^ ub;  m_v = 1'b0; end
            4'hB: begin r = ~ua;      m_v = 1'b0; end
            default: e.err = 1'b1;
        endcase
        r = r & MASK;
        e.res = r[W-1:0];
        if (!e.err) begin
            m_z = (e.res == '0);
            m_n = e.res[W-1];
        end
        e.c = m_c;
        e.z = m_z;
        e.n = m_n;
        e.v = m_v;
        return e;
    endfunction

    function automatic logic model_busy();
        return (sh_n > 0) && ((cyc - sh_acc) < sh_n);
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        pop_seen <= out_valid && out_ready;
    end

    always @(negedge clk) begin : compare
        exp_t e;
        if (rst) begin
            was_valid <= 1'b0;
        end else begin
            chk("busy", busy, model_busy());
            if (out_valid) begin
                if (!was_valid || pop_seen) begin
                    if (q.size() == 0) begin
                        failures++;
                        checks++;
                        $display("FAIL unexpected_result got=%0h required=none", result);
                    end else begin
                        e = q.pop_front();
                        chk("result", result, e.res);
                        chk("flag_c", flag_c, e.c);
                        chk("flag_z", flag_z, e.z);
                        chk("flag_n", flag_n, e.n);
                        chk("flag_v", flag_v, e.v);
                        chk("op_err", op_err, e.err);
                        chk("latency", cyc - e.acc + 1, e.lat);
                    end
                    h_res <= result;
                    h_c   <= flag_c;
                    h_z   <= flag_z;
                    h_n   <= flag_n;
                    h_v   <= flag_v;
                    h_err <= op_err;
                end else begin
                    chk("hold_result", result, h_res);
                    chk("hold_flags", {flag_c, flag_z, flag_n, flag_v, op_err},
                        {h_c, h_z, h_n, h_v, h_err});
                end
            end else if (was_valid && !pop_seen) begin
                failures++;
                checks++;
                $display("FAIL out_valid_dropped got=0 required=1");
            end
            was_valid <= out_valid;
        end
    end

    task automatic cycle(input logic iv, input logic [3:0] o, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic ordy,
                         output logic acc, output exp_t e);
        @(negedge clk);
        #2;
        in_valid  = iv;
        op_i      = o;
        a_i       = av;
        b_i       = bv;
        out_ready = ordy;
        #1;
        chk("in_ready", in_ready, !model_busy() && (!out_valid || ordy));
        acc = iv && in_ready;
        e = '{default: 0};
        @(posedge clk);
        #1;
        if (acc) begin
            e = model_step(o, av, bv);
            e.acc = cyc;
            q.push_back(e);
            if (e.lat > 1) begin
                sh_acc = cyc;
                sh_n   = e.lat - 1;
            end
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [W-1:0] av,
                         input logic [W-1:0] bv, output exp_t e);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 40 && !acc; t++) begin
            cycle(1'b1, o, av, bv, 1'b1, acc, e);
        end
        if (!acc) begin
            failures++;
            checks++;
            $display("FAIL issue_timeout got=no_accept required=accept op=%0h", o);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        logic acc;
        exp_t e;
        for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, '0, '0, 1'b1, acc, e);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic acc;
        logic [3:0] ro;
        logic [W-1:0] ra, rb;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {flag_c, flag_z, flag_n, flag_v}, 0);
        chk("rst_op_err", op_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        #2 rst = 1'b0;

        issue(4'h0, 8'hFF, 8'h01, e);
        chk("pin_add_res", e.res, 8'h00);
        chk("pin_add_czv", {e.c, e.z, e.v}, 3'b110);
        issue(4'h1, 8'h10, 8'h20, e);
        chk("pin_adc_res", e.res, 8'h31);
        chk("pin_adc_c", e.c, 0);
        issue(4'h2, 8'h05, 8'h07, e);
        chk("pin_sub_res", e.res, 8'hFE);
        chk("pin_sub_cnv", {e.c, e.n, e.v}, 3'b110);
        issue(4'h3, 8'h10, 8'h01, e);
        chk("pin_sbb_res", e.res, 8'h0E);
        chk("pin_sbb_c", e.c, 0);
        issue(4'h2, 8'h80, 8'h01, e);
        chk("pin_subv_res", e.res, 8'h7F);
        chk("pin_subv_v", e.v, 1);
        issue(4'h4, 8'h80, 8'h03, e);
        chk("pin_asr_res", e.res, 8'hF0);
        chk("pin_asr_n", e.n, 1);
        issue(4'h6, 8'h81, 8'h01, e);
        chk("pin_ror_res", e.res, 8'hC0);
        issue(4'h5, 8'h81, 8'h00, e);
        chk("pin_lsr0_res", e.res, 8'h81);
        chk("pin_lsr0_lat", e.lat, 1);
        idle(2);

        issue(4'h9, 8'hF0, 8'h3C, e);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 4'h0, 8'h01, 8'h01, 1'b0, acc, e);
            chk("hold_no_accept", acc, 0);
        end
        cycle(1'b1, 4'h0, 8'h02, 8'h03, 1'b1, acc, e);
        chk("pop_and_accept", acc, 1);
        in_valid = 1'b0;
        idle(2);

        issue(4'h0, 8'hFF, 8'h01, e);
        issue(4'hE, 8'h12, 8'h34, e);
        chk("pin_illegal_res", e.res, 8'h00);
        chk("pin_illegal_err", e.err, 1);
        chk("pin_illegal_c", e.c, 1);
        issue(4'h9, 8'h0F, 8'h05, e);
        chk("pin_and_err", e.err, 0);
        idle(2);

        issue(4'h4, 8'h80, 8'h07, e);
        idle(1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        q.delete();
        sh_n = 0;
        m_c = 1'b0; m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
        @(negedge clk);
        #3;
        chk("postrst_out_valid", out_valid, 0);
        chk("postrst_busy", busy, 0);
        chk("postrst_flags", {flag_c, flag_z, flag_n, flag_v, op_err}, 0);
        chk("postrst_in_ready", in_ready, 1);
        idle(12);

        for (int i = 0; i < 1500; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 7) == 0) ra = W'(MASK);
            cycle(($urandom_range(0, 2) != 0), ro, ra, rb, ($urandom_range(0, 3) != 0), acc, e);
        end
        in_valid = 1'b0;
        idle(20);
        chk("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
